dxa_core_issuer: RTL and testbench
==================================

// Module: dxa_core_issuer
// PURPOSE
//  Per-core initiator of the DXA request/response protocol. Accepts DXA ops (SETUP0..LAUNCH) from the core
//  execute path, packs and forwards them to the shared DXA engine, and tracks in-flight transfers per warp.
//  Consumes engine completions and raises barrier-arrive notifications. Sits between the core SFU/execute
//  dispatch and the cluster-level DXA engine.
// PARAMETERS
//  CORE_ID      0           value driven in the core_id field of every request; responses must match it
//  NUM_WARPS    `NUM_WARPS  warps per core; sizes the pending table
//  MAX_PENDING  4           max in-flight ISSUE/LAUNCH transfers per warp (>=1)
// PORTS
//  clk             in   1              clock
//  reset           in   1              synchronous, active-high
//  exe_req_valid   in   1              execute-side op valid
//  exe_req_uuid    in   UUID_WIDTH     instruction uuid
//  exe_req_wid     in   NW_WIDTH       issuing warp
//  exe_req_op      in   3              DXA_OP_* code
//  exe_req_rs1     in   XLEN           operand 0
//  exe_req_rs2     in   XLEN           operand 1
//  exe_req_ready   out  1              op accepted when valid&ready
//  dxa_req_valid   out  1              request to engine
//  dxa_req_data    out  DXA_REQ_DATAW  packed {core_id, uuid, wid, op, rs2, rs1}, MSB first
//  dxa_req_ready   in   1              engine accepts
//  dxa_rsp_valid   in   1              completion from engine
//  dxa_rsp_data    in   DXA_RSP_DATAW  packed {core_id, uuid, wid, bar_addr, status[1:0]}
//  dxa_rsp_ready   out  1              completion consumed
//  bar_valid       out  1              barrier-arrive notification
//  bar_wid         out  NW_WIDTH       warp of completed transfer
//  bar_addr        out  BAR_ADDR_W     barrier to arrive on
//  bar_err         out  1              transfer completed with error
//  bar_ready       in   1              barrier unit accepts
//  warp_busy       out  NUM_WARPS      bit w set while pending[w] != 0 (used by fence logic)
// BEHAVIOUR
//  Reset: exe_req_ready=0 during reset, 1 the cycle after; dxa_req_valid=0, bar_valid=0, warp_busy=0,
//   pending table cleared, request buffer flushed, all perf counters 0.
//  Request path: 2-entry elastic buffer; accepted op visible on dxa_req_valid next cycle (latency 1);
//   full throughput 1 op/cycle while dxa_req_ready=1. dxa_req_valid/data held stable until dxa_req_ready.
//  Backpressure: exe_req_ready = buffer not full AND NOT (op in {ISSUE,LAUNCH} AND pending[wid]==MAX_PENDING).
//  Transfer ops (ISSUE, LAUNCH) increment pending[wid] on exe acceptance; SETUP0/SETUP1/COORD01/COORD23 do not.
//  Ops 6,7: accepted (ready per buffer state), dropped, not forwarded; simulation assertion fires.
//  Response path: dxa_rsp_ready = !bar_valid | bar_ready (1-entry output register). On rsp fire:
//   status[0]=done, status[1]=err. done=1 -> decrement pending[wid], load bar_* next cycle (latency 1),
//   bar_err=status[1]. done=0 -> progress-only, consumed, no counter change, no bar_valid.
//  core_id mismatch: consumed and dropped, assertion fires. done on pending[wid]==0: dropped (no bar_valid,
//   counter stays 0), assertion fires — covers stale completions after reset mid-operation.
//  Simultaneous inc and dec on same warp: net unchanged. Counter width CLOG2(MAX_PENDING+1); never wraps.
//  bar_* held stable until bar_ready; warp_busy is a registered function of the pending table.
// CONFIGURATION
//  DXA_ISSUER_PERF_EN defined: adds outputs perf_xfers (44b, ISSUE/LAUNCH accepted) and perf_stalls
//   (44b, cycles exe_req_valid&!exe_req_ready), cleared on reset, saturating. Undefined: ports and
//   counters absent; all other behaviour identical.
// STRUCTURE
//  VX_dxa_pkg gains: dxa_req_t, dxa_rsp_t packed structs matching the field orders above,
//   DXA_RSP_DONE_BIT=0, DXA_RSP_ERR_BIT=1, dxa_is_xfer_op() function.
//  One sub-module: dxa_pending_table (per-warp up/down counters, full flags, busy vector).
//  Request buffer reuses the existing elastic buffer primitive.
// TESTING
//  SETUP0,SETUP1,COORD01,ISSUE from wid=2, dxa_req_ready=1 -> 4 requests in order, 1 per cycle,
//   pending[2]=1, warp_busy=0x4.
//  MAX_PENDING=4, 5 ISSUEs wid=1 with no rsp -> 5th held (exe_req_ready=0); rsp done wid=1 -> 5th accepted.
//  rsp {CORE_ID, wid=1, bar_addr=3, status=2'b11} with bar_ready=0 for 3 cycles -> bar_valid held,
//   bar_addr=3, bar_err=1, dxa_rsp_ready=0 until bar_ready.
//  Same-cycle ISSUE accept and done rsp for wid=0 with pending[0]=2 -> pending[0] stays 2.
//  Reset with 3 pending, then done rsp wid=0 -> dropped, bar_valid=0, warp_busy=0.
//  rsp core_id != CORE_ID or status=2'b00 -> consumed, no bar_valid, pending unchanged.

Source files
------------

// File: rtl/dxa_core_issuer_pkg.sv
// Shared types, widths and op codes for the per-core DXA issuer.
// NUM_WARPS may be overridden from the command line via `NUM_WARPS.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif

package dxa_core_issuer_pkg;

   localparam int unsigned NUM_WARPS  = `NUM_WARPS;
   localparam int unsigned NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
   localparam int unsigned UUID_WIDTH = 8;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned BAR_ADDR_W = 5;
   localparam int unsigned CORE_ID_W  = 4;
   localparam int unsigned DXA_OP_W   = 3;
   localparam int unsigned PERF_W     = 44;

   localparam int unsigned DXA_RSP_DONE_BIT = 0;
   localparam int unsigned DXA_RSP_ERR_BIT  = 1;

   typedef enum logic [DXA_OP_W-1:0] {
      DXA_OP_SETUP0  = 3'd0,
      DXA_OP_SETUP1  = 3'd1,
      DXA_OP_COORD01 = 3'd2,
      DXA_OP_COORD23 = 3'd3,
      DXA_OP_ISSUE   = 3'd4,
      DXA_OP_LAUNCH  = 3'd5
   } dxa_op_e;

   typedef struct packed {
      logic [CORE_ID_W-1:0]  core_id;
      logic [UUID_WIDTH-1:0] uuid;
      logic [NW_WIDTH-1:0]   wid;
      logic [DXA_OP_W-1:0]   op;
      logic [XLEN-1:0]       rs2;
      logic [XLEN-1:0]       rs1;
   } dxa_req_t;

   typedef struct packed {
      logic [CORE_ID_W-1:0]  core_id;
      logic [UUID_WIDTH-1:0] uuid;
      logic [NW_WIDTH-1:0]   wid;
      logic [BAR_ADDR_W-1:0] bar_addr;
      logic [1:0]            status;
   } dxa_rsp_t;

   localparam int unsigned DXA_REQ_DATAW = $bits(dxa_req_t);
   localparam int unsigned DXA_RSP_DATAW = $bits(dxa_rsp_t);

   // Transfer ops occupy a pending slot until their completion returns
   function automatic logic dxa_is_xfer_op(input logic [DXA_OP_W-1:0] op);
      return (op == DXA_OP_ISSUE) || (op == DXA_OP_LAUNCH);
   endfunction

endpackage

// File: rtl/dxa_core_issuer_if.sv
// Bundle of execute-side, engine-side and barrier-side handshakes around the issuer.
// master = issuer view, slave = surrounding core/engine/barrier view.
interface dxa_core_issuer_if;
   import dxa_core_issuer_pkg::*;

   logic                     exe_req_valid;
   logic [UUID_WIDTH-1:0]    exe_req_uuid;
   logic [NW_WIDTH-1:0]      exe_req_wid;
   logic [DXA_OP_W-1:0]      exe_req_op;
   logic [XLEN-1:0]          exe_req_rs1;
   logic [XLEN-1:0]          exe_req_rs2;
   logic                     exe_req_ready;

   logic                     dxa_req_valid;
   logic [DXA_REQ_DATAW-1:0] dxa_req_data;
   logic                     dxa_req_ready;

   logic                     dxa_rsp_valid;
   logic [DXA_RSP_DATAW-1:0] dxa_rsp_data;
   logic                     dxa_rsp_ready;

   logic                     bar_valid;
   logic [NW_WIDTH-1:0]      bar_wid;
   logic [BAR_ADDR_W-1:0]    bar_addr;
   logic                     bar_err;
   logic                     bar_ready;

   logic [NUM_WARPS-1:0]     warp_busy;

   modport master (
      input  exe_req_valid, exe_req_uuid, exe_req_wid, exe_req_op, exe_req_rs1, exe_req_rs2,
      output exe_req_ready,
      output dxa_req_valid, dxa_req_data,
      input  dxa_req_ready,
      input  dxa_rsp_valid, dxa_rsp_data,
      output dxa_rsp_ready,
      output bar_valid, bar_wid, bar_addr, bar_err,
      input  bar_ready,
      output warp_busy
   );

   modport slave (
      output exe_req_valid, exe_req_uuid, exe_req_wid, exe_req_op, exe_req_rs1, exe_req_rs2,
      input  exe_req_ready,
      input  dxa_req_valid, dxa_req_data,
      output dxa_req_ready,
      output dxa_rsp_valid, dxa_rsp_data,
      input  dxa_rsp_ready,
      input  bar_valid, bar_wid, bar_addr, bar_err,
      output bar_ready,
      input  warp_busy
   );

endinterface

// File: rtl/dxa_pending_table.sv
// Per-warp in-flight transfer counters with full/empty flags and a registered busy vector.
module dxa_pending_table
   import dxa_core_issuer_pkg::*;
#(
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc_valid,
   input  logic [NW_WIDTH-1:0]  inc_wid,
   input  logic                 dec_valid,
   input  logic [NW_WIDTH-1:0]  dec_wid,
   output logic [NUM_WARPS-1:0] full_c,
   output logic [NUM_WARPS-1:0] empty_c,
   output logic [NUM_WARPS-1:0] busy
);

   localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

   logic [CNT_W-1:0]     cnt_q [NUM_WARPS];
   logic [CNT_W-1:0]     cnt_d [NUM_WARPS];
   logic [NUM_WARPS-1:0] inc_hit_c;
   logic [NUM_WARPS-1:0] dec_hit_c;

   // Saturating up/down per warp; a coincident inc and dec cancel out
   always_comb begin
      full_c    = '0;
      empty_c   = '0;
      inc_hit_c = '0;
      dec_hit_c = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         cnt_d[w]     = cnt_q[w];
         full_c[w]    = (cnt_q[w] == CNT_W'(MAX_PENDING));
         empty_c[w]   = (cnt_q[w] == '0);
         inc_hit_c[w] = inc_valid && (inc_wid == NW_WIDTH'(w)) && !full_c[w];
         dec_hit_c[w] = dec_valid && (dec_wid == NW_WIDTH'(w)) && !empty_c[w];
         if (inc_hit_c[w] && !dec_hit_c[w]) begin
            cnt_d[w] = cnt_q[w] + CNT_W'(1);
         end else if (dec_hit_c[w] && !inc_hit_c[w]) begin
            cnt_d[w] = cnt_q[w] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_q[w] <= '0;
         end
         busy <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_q[w] <= cnt_d[w];
            busy[w]  <= (cnt_d[w] != '0);
         end
      end
   end

endmodule

// File: rtl/dxa_core_issuer.sv
// Per-core DXA request issuer: buffers execute-side ops toward the engine and turns completions
// into barrier arrivals. Optional perf counters under DXA_ISSUER_PERF_EN.
module dxa_core_issuer
   import dxa_core_issuer_pkg::*;
#(
   parameter int unsigned CORE_ID     = 0,
   parameter int unsigned MAX_PENDING = 4
) (
   input  logic clk,
   input  logic reset,
   dxa_core_issuer_if.master bus
`ifdef DXA_ISSUER_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_xfers,
   output logic [PERF_W-1:0] perf_stalls
`endif
);

   logic                 exe_xfer_c;
   logic                 exe_op_ok_c;
   logic                 exe_fire_c;
   logic                 push_c;
   logic                 pop_c;
   logic                 buf_full_c;
   logic [NUM_WARPS-1:0] pend_full_c;
   logic [NUM_WARPS-1:0] pend_empty_c;
   logic [NUM_WARPS-1:0] warp_busy_q;
   dxa_req_t             req_c;

   dxa_req_t   buf_q [2];
   logic       rd_ptr_q;
   logic       wr_ptr_q;
   logic [1:0] buf_cnt_q;

   assign exe_xfer_c  = dxa_is_xfer_op(bus.exe_req_op);
   assign exe_op_ok_c = (bus.exe_req_op <= DXA_OP_W'(DXA_OP_LAUNCH));
   assign buf_full_c  = (buf_cnt_q == 2'd2);

   assign bus.exe_req_ready = !reset && !buf_full_c
                              && !(exe_xfer_c && pend_full_c[bus.exe_req_wid]);
   assign exe_fire_c = bus.exe_req_valid && bus.exe_req_ready;
   // Reserved op codes are swallowed here and never reach the engine
   assign push_c     = exe_fire_c && exe_op_ok_c;
   assign pop_c      = bus.dxa_req_valid && bus.dxa_req_ready;

   always_comb begin
      req_c         = '0;
      req_c.core_id = CORE_ID_W'(CORE_ID);
      req_c.uuid    = bus.exe_req_uuid;
      req_c.wid     = bus.exe_req_wid;
      req_c.op      = bus.exe_req_op;
      req_c.rs2     = bus.exe_req_rs2;
      req_c.rs1     = bus.exe_req_rs1;
   end

   // Two-entry elastic buffer: latency 1, full rate while the engine keeps up
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         buf_cnt_q <= '0;
      end else begin
         if (push_c) wr_ptr_q <= ~wr_ptr_q;
         if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
         case ({push_c, pop_c})
            2'b10:   buf_cnt_q <= buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_q <= buf_cnt_q - 2'd1;
            default: buf_cnt_q <= buf_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) buf_q[wr_ptr_q] <= req_c;
   end

   assign bus.dxa_req_valid = (buf_cnt_q != '0);
   assign bus.dxa_req_data  = buf_q[rd_ptr_q];

   dxa_rsp_t              rsp_c;
   logic                  rsp_ready_c;
   logic                  rsp_fire_c;
   logic                  id_ok_c;
   logic                  done_c;
   logic                  stale_c;
   logic                  bar_load_c;
   logic                  bar_valid_q;
   logic [NW_WIDTH-1:0]   bar_wid_q;
   logic [BAR_ADDR_W-1:0] bar_addr_q;
   logic                  bar_err_q;
   logic                  unused_rsp_uuid;

   assign rsp_c           = bus.dxa_rsp_data;
   // Response uuid is carried for tracing only
   assign unused_rsp_uuid = ^rsp_c.uuid;
   assign rsp_ready_c     = !bar_valid_q || bus.bar_ready;
   assign rsp_fire_c      = bus.dxa_rsp_valid && rsp_ready_c;
   assign id_ok_c         = (rsp_c.core_id == CORE_ID_W'(CORE_ID));
   assign done_c          = rsp_c.status[DXA_RSP_DONE_BIT];
   assign stale_c         = done_c && pend_empty_c[rsp_c.wid];
   assign bar_load_c      = rsp_fire_c && id_ok_c && done_c && !stale_c;

   // One-entry barrier notification register, held until the barrier unit takes it
   always_ff @(posedge clk) begin
      if (reset) begin
         bar_valid_q <= 1'b0;
         bar_wid_q   <= '0;
         bar_addr_q  <= '0;
         bar_err_q   <= 1'b0;
      end else if (bar_load_c) begin
         bar_valid_q <= 1'b1;
         bar_wid_q   <= rsp_c.wid;
         bar_addr_q  <= rsp_c.bar_addr;
         bar_err_q   <= rsp_c.status[DXA_RSP_ERR_BIT];
      end else if (bus.bar_ready) begin
         bar_valid_q <= 1'b0;
      end
   end

   assign bus.dxa_rsp_ready = rsp_ready_c;
   assign bus.bar_valid     = bar_valid_q;
   assign bus.bar_wid       = bar_wid_q;
   assign bus.bar_addr      = bar_addr_q;
   assign bus.bar_err       = bar_err_q;

   dxa_pending_table #(
      .MAX_PENDING (MAX_PENDING)
   ) u_pending (
      .clk       (clk),
      .reset     (reset),
      .inc_valid (exe_fire_c && exe_xfer_c),
      .inc_wid   (bus.exe_req_wid),
      .dec_valid (bar_load_c),
      .dec_wid   (rsp_c.wid),
      .full_c    (pend_full_c),
      .empty_c   (pend_empty_c),
      .busy      (warp_busy_q)
   );

   assign bus.warp_busy = warp_busy_q;

`ifdef DXA_ISSUER_PERF_EN
   // Saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_xfers  <= '0;
         perf_stalls <= '0;
      end else begin
         if (exe_fire_c && exe_xfer_c && (perf_xfers != '1))
            perf_xfers <= perf_xfers + PERF_W'(1);
         if (bus.exe_req_valid && !bus.exe_req_ready && (perf_stalls != '1))
            perf_stalls <= perf_stalls + PERF_W'(1);
      end
   end
`endif

   // Protocol anomalies that are tolerated in hardware but flagged in simulation
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(exe_fire_c && !exe_op_ok_c))
            else $warning("dxa_core_issuer: reserved op %0d dropped", bus.exe_req_op);
         assert (!(rsp_fire_c && !id_ok_c))
            else $warning("dxa_core_issuer: response for core %0d dropped", rsp_c.core_id);
         assert (!(rsp_fire_c && id_ok_c && stale_c))
            else $warning("dxa_core_issuer: stale completion for warp %0d dropped", rsp_c.wid);
      end
   end

endmodule

// File: tb/tb_dxa_core_issuer.sv
// Directed bench for dxa_core_issuer: request ordering, per-warp backpressure, barrier hold,
// simultaneous inc/dec, reset flush and dropped responses.
module tb_dxa_core_issuer;
   import dxa_core_issuer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dxa_core_issuer_if bus ();

`ifdef DXA_ISSUER_PERF_EN
   logic [PERF_W-1:0] perf_xfers;
   logic [PERF_W-1:0] perf_stalls;
`endif

   dxa_core_issuer #(
      .CORE_ID     (0),
      .MAX_PENDING (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef DXA_ISSUER_PERF_EN
      ,
      .perf_xfers  (perf_xfers),
      .perf_stalls (perf_stalls)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic exe(input logic v, input int wid, input logic [2:0] op, input int tag);
      bus.exe_req_valid = v;
      bus.exe_req_wid   = NW_WIDTH'(wid);
      bus.exe_req_op    = op;
      bus.exe_req_uuid  = UUID_WIDTH'(tag);
      bus.exe_req_rs1   = XLEN'(32'h1000 + tag);
      bus.exe_req_rs2   = XLEN'(32'hA000 + tag);
   endtask

   function automatic dxa_req_t mk_req(input int wid, input logic [2:0] op, input int tag);
      dxa_req_t r;
      r.core_id = '0;
      r.uuid    = UUID_WIDTH'(tag);
      r.wid     = NW_WIDTH'(wid);
      r.op      = op;
      r.rs2     = XLEN'(32'hA000 + tag);
      r.rs1     = XLEN'(32'h1000 + tag);
      return r;
   endfunction

   task automatic rsp(input logic v, input int core, input int wid, input int addr,
                      input logic [1:0] st);
      dxa_rsp_t r;
      r.core_id         = CORE_ID_W'(core);
      r.uuid            = '0;
      r.wid             = NW_WIDTH'(wid);
      r.bar_addr        = BAR_ADDR_W'(addr);
      r.status          = st;
      bus.dxa_rsp_valid = v;
      bus.dxa_rsp_data  = r;
   endtask

   logic [2:0] ops [4];

   initial begin
      ops[0] = DXA_OP_SETUP0;
      ops[1] = DXA_OP_SETUP1;
      ops[2] = DXA_OP_COORD01;
      ops[3] = DXA_OP_ISSUE;

      reset = 1'b1;
      exe(1'b0, 0, 3'd0, 0);
      rsp(1'b0, 0, 0, 0, 2'b00);
      bus.dxa_req_ready = 1'b1;
      bus.bar_ready     = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_exe_ready", 128'(bus.exe_req_ready), 128'(0));
      check("rst_req_valid", 128'(bus.dxa_req_valid), 128'(0));
      check("rst_bar_valid", 128'(bus.bar_valid), 128'(0));
      check("rst_warp_busy", 128'(bus.warp_busy), 128'(0));
      reset = 1'b0;
      #1 check("post_rst_exe_ready", 128'(bus.exe_req_ready), 128'(1));

      // Four ops from warp 2 stream through in order, one per cycle
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check("t1_req_valid", 128'(bus.dxa_req_valid), 128'(1));
            check("t1_req_data", 128'(bus.dxa_req_data), 128'(mk_req(2, ops[i-1], i - 1)));
         end
         if (i < 4) begin
            exe(1'b1, 2, ops[i], i);
            #1 check("t1_exe_ready", 128'(bus.exe_req_ready), 128'(1));
         end else begin
            exe(1'b0, 0, 3'd0, 0);
         end
      end
      @(negedge clk);
      check("t1_drained", 128'(bus.dxa_req_valid), 128'(0));
      check("t1_warp_busy", 128'(bus.warp_busy), 128'(4'h4));

      // Warp 1 fills to MAX_PENDING; a completion frees the fifth ISSUE
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exe(1'b1, 1, DXA_OP_ISSUE, 16 + i);
         #1 check("t2_accept", 128'(bus.exe_req_ready), 128'(1));
      end
      @(negedge clk);
      exe(1'b1, 1, DXA_OP_ISSUE, 20);
      rsp(1'b1, 0, 1, 7, 2'b01);
      #1 check("t2_fifth_held", 128'(bus.exe_req_ready), 128'(0));
      @(negedge clk);
      rsp(1'b0, 0, 0, 0, 2'b00);
      #1 check("t2_fifth_accept", 128'(bus.exe_req_ready), 128'(1));
      check("t2_bar_valid", 128'(bus.bar_valid), 128'(1));
      check("t2_bar_wid", 128'(bus.bar_wid), 128'(1));
      check("t2_bar_addr", 128'(bus.bar_addr), 128'(7));
      check("t2_bar_err", 128'(bus.bar_err), 128'(0));
      @(negedge clk);
      exe(1'b0, 0, 3'd0, 0);
      check("t2_bar_cleared", 128'(bus.bar_valid), 128'(0));
      check("t2_warp_busy", 128'(bus.warp_busy), 128'(4'h6));

      // Barrier stalled for three cycles holds the notification and blocks responses
      @(negedge clk);
      bus.bar_ready = 1'b0;
      rsp(1'b1, 0, 1, 3, 2'b11);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rsp(1'b0, 0, 0, 0, 2'b00);
         check("t3_bar_valid", 128'(bus.bar_valid), 128'(1));
         check("t3_bar_addr", 128'(bus.bar_addr), 128'(3));
         check("t3_bar_err", 128'(bus.bar_err), 128'(1));
         check("t3_bar_wid", 128'(bus.bar_wid), 128'(1));
         check("t3_rsp_ready", 128'(bus.dxa_rsp_ready), 128'(0));
      end
      bus.bar_ready = 1'b1;
      #1 check("t3_rsp_ready_rel", 128'(bus.dxa_rsp_ready), 128'(1));
      @(negedge clk);
      check("t3_bar_cleared", 128'(bus.bar_valid), 128'(0));

      // Same-cycle ISSUE and completion on warp 0 with two pending: count stays 2
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exe(1'b1, 0, DXA_OP_ISSUE, 32 + i);
      end
      @(negedge clk);
      exe(1'b1, 0, DXA_OP_ISSUE, 34);
      rsp(1'b1, 0, 0, 5, 2'b01);
      #1 check("t4_issue_ready", 128'(bus.exe_req_ready), 128'(1));
      check("t4_rsp_ready", 128'(bus.dxa_rsp_ready), 128'(1));
      @(negedge clk);
      rsp(1'b0, 0, 0, 0, 2'b00);
      exe(1'b1, 0, DXA_OP_ISSUE, 35);
      #1 check("t4_third", 128'(bus.exe_req_ready), 128'(1));
      check("t4_bar_addr", 128'(bus.bar_addr), 128'(5));
      check("t4_bar_valid", 128'(bus.bar_valid), 128'(1));
      @(negedge clk);
      exe(1'b1, 0, DXA_OP_ISSUE, 36);
      #1 check("t4_fourth", 128'(bus.exe_req_ready), 128'(1));
      @(negedge clk);
      exe(1'b1, 0, DXA_OP_ISSUE, 37);
      #1 check("t4_full", 128'(bus.exe_req_ready), 128'(0));

      // Foreign core id and progress-only responses are consumed without effect
      @(negedge clk);
      exe(1'b1, 3, DXA_OP_ISSUE, 40);
      @(negedge clk);
      exe(1'b0, 0, 3'd0, 0);
      rsp(1'b1, 1, 3, 2, 2'b01);
      #1 check("t6_foreign_ready", 128'(bus.dxa_rsp_ready), 128'(1));
      check("t6_busy_before", 128'(bus.warp_busy), 128'(4'hF));
      @(negedge clk);
      rsp(1'b1, 0, 3, 2, 2'b00);
      check("t6_foreign_no_bar", 128'(bus.bar_valid), 128'(0));
      check("t6_foreign_busy", 128'(bus.warp_busy), 128'(4'hF));
      @(negedge clk);
      rsp(1'b1, 0, 3, 2, 2'b01);
      check("t6_progress_no_bar", 128'(bus.bar_valid), 128'(0));
      check("t6_progress_busy", 128'(bus.warp_busy), 128'(4'hF));
      @(negedge clk);
      rsp(1'b0, 0, 0, 0, 2'b00);
      check("t6_done_bar", 128'(bus.bar_valid), 128'(1));
      check("t6_done_addr", 128'(bus.bar_addr), 128'(2));
      check("t6_done_busy", 128'(bus.warp_busy), 128'(4'h7));

      // Reserved op is accepted but never forwarded
      @(negedge clk);
      exe(1'b1, 3, 3'd6, 50);
      #1 check("t7_rsvd_ready", 128'(bus.exe_req_ready), 128'(1));
      @(negedge clk);
      exe(1'b0, 0, 3'd0, 0);
      check("t7_rsvd_dropped", 128'(bus.dxa_req_valid), 128'(0));
      check("t7_rsvd_busy", 128'(bus.warp_busy), 128'(4'h7));

      // Engine stalled: buffer fills at two entries, head held stable
      bus.dxa_req_ready = 1'b0;
      @(negedge clk);
      exe(1'b1, 3, DXA_OP_SETUP0, 60);
      @(negedge clk);
      exe(1'b1, 3, DXA_OP_SETUP1, 61);
      check("t8_head", 128'(bus.dxa_req_data), 128'(mk_req(3, DXA_OP_SETUP0, 60)));
      @(negedge clk);
      exe(1'b1, 3, DXA_OP_COORD23, 62);
      #1 check("t8_buf_full", 128'(bus.exe_req_ready), 128'(0));
      check("t8_head_held", 128'(bus.dxa_req_data), 128'(mk_req(3, DXA_OP_SETUP0, 60)));

      // Reset mid-operation flushes the buffer and pending table; stale completion dropped
      @(negedge clk);
      exe(1'b0, 0, 3'd0, 0);
      reset = 1'b1;
      #1 check("t5_rst_ready", 128'(bus.exe_req_ready), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      bus.dxa_req_ready = 1'b1;
      check("t5_flushed", 128'(bus.dxa_req_valid), 128'(0));
      check("t5_busy_clr", 128'(bus.warp_busy), 128'(0));
`ifdef DXA_ISSUER_PERF_EN
      check("t5_perf_clr", 128'(perf_xfers), 128'(0));
`endif
      rsp(1'b1, 0, 0, 4, 2'b01);
      #1 check("t5_stale_ready", 128'(bus.dxa_rsp_ready), 128'(1));
      @(negedge clk);
      rsp(1'b0, 0, 0, 0, 2'b00);
      check("t5_stale_no_bar", 128'(bus.bar_valid), 128'(0));
      check("t5_stale_busy", 128'(bus.warp_busy), 128'(0));
      @(negedge clk);
      check("t5_stale_busy2", 128'(bus.warp_busy), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
